coffee_brewer: RTL and testbench

Brew-unit controller on the consumer side of the vending machine's `COFFEE`/`WATER`/`BEANS` interface. It accepts a single-cycle brew request pulse, runs a fixed grind -> heat -> pour sequence that drives the actuators, and tracks the water tank level and bean dose stock. It reports both back as the `water_level` and `beans_ok` status that the vending FSM samples. It also arbitrates refill commands and flags requests it cannot serve.

---
 rtl/coffee_brewer.sv | 129 ++++++++++++
 tb/tb_coffee_brewer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/coffee_brewer.sv
// Brew-unit controller: sequences grind -> heat -> pour for each accepted request,
// tracks tank level and bean doses, and flags requests it cannot serve.
module coffee_brewer #(
  parameter int WATER_MAX     = 31,
  parameter int WATER_PER_CUP = 2,
  parameter int BEAN_DOSES    = 10,
  parameter int GRIND_CYCLES  = 4,
  parameter int HEAT_CYCLES   = 8,
  parameter int POUR_CYCLES   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coffee_req,
  input  logic       refill_water,
  input  logic       refill_beans,
  output logic [4:0] water_level,
  output logic       beans_ok,
  output logic       busy,
  output logic       grinder,
  output logic       heater,
  output logic       pump,
  output logic       brew_done,
  output logic       brew_fault,
  output logic       req_dropped
);

  typedef enum logic [2:0] {IDLE, GRIND, HEAT, POUR, DONE} state_t;

  localparam logic [4:0] W_MAX  = 5'(WATER_MAX);
  localparam logic [4:0] W_CUP  = 5'(WATER_PER_CUP);
  localparam logic [7:0] B_FULL = 8'(BEAN_DOSES);
  // Phase counter counts down from length-1 so each phase lasts exactly its length.
  localparam logic [7:0] G_LAST = 8'(GRIND_CYCLES - 1);
  localparam logic [7:0] H_LAST = 8'(HEAT_CYCLES - 1);
  localparam logic [7:0] P_LAST = 8'(POUR_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] phase, phase_nx;
  logic [4:0] water, water_nx;
  logic [7:0] doses, doses_nx;
  logic       fault_q, fault_nx;
  logic       drop_q, drop_nx;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_nx = state;
    phase_nx = phase;
    water_nx = water;
    doses_nx = doses;
    fault_nx = 1'b0;
    drop_nx  = 1'b0;

    if (state != IDLE) drop_nx = coffee_req;

    case (state)
      IDLE: begin
        if (refill_water || refill_beans) begin
          if (refill_water) water_nx = W_MAX;
          if (refill_beans) doses_nx = B_FULL;
          drop_nx = coffee_req;
        end else if (coffee_req) begin
          if (water < W_CUP || doses == 8'd0) begin
            fault_nx = 1'b1;
          end else begin
            state_nx = GRIND;
            doses_nx = doses - 8'd1;
            phase_nx = G_LAST;
          end
        end
      end
      GRIND: begin
        if (phase == 8'd0) begin
          state_nx = HEAT;
          phase_nx = H_LAST;
        end else begin
          phase_nx = phase - 8'd1;
        end
      end
      HEAT: begin
        if (phase == 8'd0) begin
          state_nx = POUR;
          phase_nx = P_LAST;
          water_nx = water - W_CUP;
        end else begin
          phase_nx = phase - 8'd1;
        end
      end
      POUR: begin
        if (phase == 8'd0) begin
          state_nx = DONE;
        end else begin
          phase_nx = phase - 8'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= 8'd0;
      water   <= 5'd0;
      doses   <= 8'd0;
      fault_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      phase   <= phase_nx;
      water   <= water_nx;
      doses   <= doses_nx;
      fault_q <= fault_nx;
      drop_q  <= drop_nx;
    end
  end

  assign water_level = water;
  assign beans_ok    = (doses != 8'd0);
  assign busy        = (state != IDLE);
  assign grinder     = (state == GRIND);
  assign heater      = (state == HEAT) || (state == POUR);
  assign pump        = (state == POUR);
  assign brew_done   = (state == DONE);
  assign brew_fault  = fault_q;
  assign req_dropped = drop_q;

endmodule

// File: tb/tb_coffee_brewer.sv
// Bench for coffee_brewer: directed scenarios followed by random traffic, all
// checked every cycle against a brew-timeline model of the unit.
module tb_coffee_brewer;

  localparam int WMAX  = 31;
  localparam int WCUP  = 2;
  localparam int BEANS = 10;
  localparam int G     = 4;
  localparam int H     = 8;
  localparam int P     = 6;
  localparam int TOTAL = G + H + P + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coffee_req = 1'b0;
  logic       refill_water = 1'b0;
  logic       refill_beans = 1'b0;
  logic [4:0] water_level;
  logic       beans_ok, busy, grinder, heater, pump, brew_done, brew_fault, req_dropped;

  coffee_brewer #(
    .WATER_MAX(WMAX), .WATER_PER_CUP(WCUP), .BEAN_DOSES(BEANS),
    .GRIND_CYCLES(G), .HEAT_CYCLES(H), .POUR_CYCLES(P)
  ) dut (
    .clk(clk), .rst(rst), .coffee_req(coffee_req),
    .refill_water(refill_water), .refill_beans(refill_beans),
    .water_level(water_level), .beans_ok(beans_ok), .busy(busy),
    .grinder(grinder), .heater(heater), .pump(pump),
    .brew_done(brew_done), .brew_fault(brew_fault), .req_dropped(req_dropped)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int checks = 0;
  int miscompares = 0;

  // Model: m_t is the cycle index within the current brew (-1 when idle).
  int m_water = 0;
  int m_doses = 0;
  int m_t = -1;
  int m_fault = 0;
  int m_drop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic req, input logic rw, input logic rb);
    if (r) begin
      m_water = 0; m_doses = 0; m_t = -1; m_fault = 0; m_drop = 0;
    end else begin
      m_fault = 0;
      m_drop  = 0;
      if (m_t >= 0) begin
        m_drop = int'(req);
        m_t++;
        if (m_t == G + H) m_water -= WCUP;
        if (m_t == TOTAL) m_t = -1;
      end else if (rw || rb) begin
        if (rw) m_water = WMAX;
        if (rb) m_doses = BEANS;
        m_drop = int'(req);
      end else if (req) begin
        if (m_water < WCUP || m_doses == 0) m_fault = 1;
        else begin
          m_doses--;
          m_t = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("water_level", 32'(water_level), 32'(m_water));
    check("beans_ok",    32'(beans_ok),    32'(m_doses != 0));
    check("busy",        32'(busy),        32'(m_t >= 0));
    check("grinder",     32'(grinder),     32'(m_t >= 0 && m_t < G));
    check("heater",      32'(heater),      32'(m_t >= G && m_t < G + H + P));
    check("pump",        32'(pump),        32'(m_t >= G + H && m_t < G + H + P));
    check("brew_done",   32'(brew_done),   32'(m_t == TOTAL - 1));
    check("brew_fault",  32'(brew_fault),  32'(m_fault));
    check("req_dropped", 32'(req_dropped), 32'(m_drop));
  endtask

  task automatic step(input logic r, input logic req, input logic rw, input logic rb);
    rst = r; coffee_req = req; refill_water = rw; refill_beans = rb;
    @(posedge clk);
    model_update(r, req, rw, rb);
    vectors++;
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_t >= 0; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("drain_timeout", 32'(m_t >= 0), 32'd0);
  endtask

  int busy_cnt;
  int done_cnt;
  logic [3:0] rnd;

  initial begin
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    check("reset_water", 32'(water_level), 32'd0);
    check("reset_beans", 32'(beans_ok), 32'd0);

    // Request on an empty unit is rejected.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("empty_fault", 32'(brew_fault), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    idle(1);

    // Full brew with default timing.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cnt++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("busy_len", 32'(busy_cnt), 32'(19));
    check("water_after_1", 32'(water_level), 32'd29);

    // Requests on the 3rd and 10th busy cycles are dropped.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 40 && m_t >= 0; i++) begin
      step(1'b0, logic'(m_t == 2 || m_t == 9), 1'b0, 1'b0);
      if (brew_done) done_cnt++;
    end
    check("one_brew", 32'(done_cnt), 32'd1);

    // Refill coincident with request: refill wins, request dropped.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("refill_wins_level", 32'(water_level), 32'd31);
    check("refill_wins_drop", 32'(req_dropped), 32'd1);
    check("refill_wins_busy", 32'(busy), 32'd0);

    // Bean refill during HEAT is ignored.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40 && m_t >= 0; i++)
      step(1'b0, 1'b0, 1'b0, logic'(m_t == G + 2));
    drain();

    // Water limit: 15 brews, the 16th is rejected.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      drain();
    end
    check("water_left", 32'(water_level), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("water_fault", 32'(brew_fault), 32'd1);

    // Bean limit: 10 brews, the 11th is rejected.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      drain();
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("bean_fault", 32'(brew_fault), 32'd1);
    check("bean_empty", 32'(beans_ok), 32'd0);

    // Reset during POUR.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40 && m_t != G + H + 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("in_pour", 32'(pump), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_heater", 32'(heater), 32'd0);
    check("rst_pump", 32'(pump), 32'd0);
    check("rst_done", 32'(brew_done), 32'd0);
    check("rst_water", 32'(water_level), 32'd0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rnd = 4'($urandom_range(0, 15));
      step(logic'($urandom_range(0, 399) == 0),
           logic'(rnd[1:0] == 2'b00),
           logic'($urandom_range(0, 59) == 0),
           logic'($urandom_range(0, 29) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
